// File: rtl/param_rtc_alarm.sv
// -----------------------------------------------------------------------------
// param_rtc_alarm
// Real-time clock with hh:mm:ss time keeping, a one-second prescaler, time load,
// a sticky hh:mm alarm and a 12/24-hour display formatter.
//
// Parameters
//   CLK_DIV : clk cycles per one-second tick (1 .. 2^24)
//
// Ports
//   clk              : single clock, all state updates on the rising edge
//   rst              : synchronous active-high reset
//   en               : run enable for prescaler and time counters
//   ld, ld_sec/min/hr: time load strobe and values (out-of-range fields load 0)
//   al_wr, al_min/hr : alarm time write strobe and values (out-of-range -> 0)
//   al_en            : alarm match enable
//   al_clr           : alarm flag clear (a simultaneous set wins)
//   h12              : 1 selects 12-hour display format
//   sec, min, hr     : registered 24-hour time
//   tick             : one-cycle pulse on every second increment
//   alarm            : sticky alarm flag
//   disp_hr, pm      : formatted hour and afternoon indicator (combinational)
// -----------------------------------------------------------------------------
module param_rtc_alarm #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ld,
    input  logic [5:0] ld_sec,
    input  logic [5:0] ld_min,
    input  logic [4:0] ld_hr,
    input  logic       al_wr,
    input  logic [5:0] al_min,
    input  logic [4:0] al_hr,
    input  logic       al_en,
    input  logic       al_clr,
    input  logic       h12,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       tick,
    output logic       alarm,
    output logic [4:0] disp_hr,
    output logic       pm
);

    // A divide-by-one still gets a 1-bit counter so the logic stays uniform.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);

    // Replace an out-of-range seconds/minutes value with 0.
    function automatic logic [5:0] fix_60(input logic [5:0] v);
        return (v > 6'd59) ? 6'd0 : v;
    endfunction

    // Replace an out-of-range hour value with 0.
    function automatic logic [4:0] fix_24(input logic [4:0] v);
        return (v > 5'd23) ? 5'd0 : v;
    endfunction

    logic [PW-1:0] r_ps;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hr;
    logic          r_tick;
    logic          r_alarm;
    logic [5:0]    r_al_min;
    logic [4:0]    r_al_hr;

    logic          w_ps_max;
    logic          w_adv;
    logic          w_set;
    logic [5:0]    w_next_sec;
    logic [5:0]    w_next_min;
    logic [4:0]    w_next_hr;

    assign w_ps_max = (r_ps == PS_MAX);
    // A second advances only when running, at the end of the prescale period,
    // and not while a load is overriding the time.
    assign w_adv    = en & w_ps_max & ~ld;

    // Time value one second after the current one, with cascaded wraps.
    always_comb begin
        w_next_sec = r_sec;
        w_next_min = r_min;
        w_next_hr  = r_hr;
        if (r_sec == 6'd59) begin
            w_next_sec = 6'd0;
            if (r_min == 6'd59) begin
                w_next_min = 6'd0;
                if (r_hr == 5'd23) begin
                    w_next_hr = 5'd0;
                end else begin
                    w_next_hr = r_hr + 5'd1;
                end
            end else begin
                w_next_min = r_min + 6'd1;
            end
        end else begin
            w_next_sec = r_sec + 6'd1;
        end
    end

    // Alarm fires only on a tick landing exactly on hh:mm:00 (never on a load).
    assign w_set = w_adv & al_en & (w_next_hr == r_al_hr) &
                   (w_next_min == r_al_min) & (w_next_sec == 6'd0);

    // Prescaler, time counters, tick pulse, alarm registers and alarm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps     <= '0;
            r_sec    <= 6'd0;
            r_min    <= 6'd0;
            r_hr     <= 5'd0;
            r_tick   <= 1'b0;
            r_alarm  <= 1'b0;
            r_al_min <= 6'd0;
            r_al_hr  <= 5'd0;
        end else begin
            r_tick <= 1'b0;
            if (ld) begin
                r_ps  <= '0;
                r_sec <= fix_60(ld_sec);
                r_min <= fix_60(ld_min);
                r_hr  <= fix_24(ld_hr);
            end else if (en) begin
                if (w_ps_max) begin
                    r_ps   <= '0;
                    r_tick <= 1'b1;
                    r_sec  <= w_next_sec;
                    r_min  <= w_next_min;
                    r_hr   <= w_next_hr;
                end else begin
                    r_ps <= r_ps + {{(PW-1){1'b0}}, 1'b1};
                end
            end else begin
                r_ps <= r_ps;
            end

            if (al_wr) begin
                r_al_min <= fix_60(al_min);
                r_al_hr  <= fix_24(al_hr);
            end else begin
                r_al_min <= r_al_min;
                r_al_hr  <= r_al_hr;
            end

            // Set has priority over clear when both happen together.
            if (w_set) begin
                r_alarm <= 1'b1;
            end else if (al_clr) begin
                r_alarm <= 1'b0;
            end else begin
                r_alarm <= r_alarm;
            end
        end
    end

    // 12/24-hour display formatting of the current hour.
    always_comb begin
        pm      = (r_hr >= 5'd12);
        disp_hr = r_hr;
        if (!h12) begin
            disp_hr = r_hr;
        end else if (r_hr == 5'd0) begin
            disp_hr = 5'd12;
        end else if (r_hr <= 5'd12) begin
            disp_hr = r_hr;
        end else begin
            disp_hr = r_hr - 5'd12;
        end
    end

    assign sec   = r_sec;
    assign min   = r_min;
    assign hr    = r_hr;
    assign tick  = r_tick;
    assign alarm = r_alarm;

endmodule

// File: tb/tb_param_rtc_alarm.sv
module tb_param_rtc_alarm;

    logic       clk = 1'b0;
    logic       rst, en, ld, al_wr, al_en, al_clr, h12;
    logic [5:0] ld_sec, ld_min, al_min;
    logic [4:0] ld_hr, al_hr;

    // Outputs per instance: a = CLK_DIV 1, b = CLK_DIV 3, c = CLK_DIV 4
    logic [5:0] sec_a, min_a, sec_b, min_b, sec_c, min_c;
    logic [4:0] hr_a, hr_b, hr_c, dhr_a, dhr_b, dhr_c;
    logic       tick_a, tick_b, tick_c, al_a, al_b, al_c, pm_a, pm_b, pm_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_rtc_alarm #(.CLK_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .al_wr(al_wr), .al_min(al_min), .al_hr(al_hr), .al_en(al_en),
        .al_clr(al_clr), .h12(h12), .sec(sec_a), .min(min_a), .hr(hr_a),
        .tick(tick_a), .alarm(al_a), .disp_hr(dhr_a), .pm(pm_a));

    param_rtc_alarm #(.CLK_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .al_wr(al_wr), .al_min(al_min), .al_hr(al_hr), .al_en(al_en),
        .al_clr(al_clr), .h12(h12), .sec(sec_b), .min(min_b), .hr(hr_b),
        .tick(tick_b), .alarm(al_b), .disp_hr(dhr_b), .pm(pm_b));

    param_rtc_alarm #(.CLK_DIV(4)) dut_c (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_sec(ld_sec), .ld_min(ld_min),
        .ld_hr(ld_hr), .al_wr(al_wr), .al_min(al_min), .al_hr(al_hr), .al_en(al_en),
        .al_clr(al_clr), .h12(h12), .sec(sec_c), .min(min_c), .hr(hr_c),
        .tick(tick_c), .alarm(al_c), .disp_hr(dhr_c), .pm(pm_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ld = 1'b1; ld_hr = h; ld_min = m; ld_sec = s;
        step();
        ld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ld = 1'b0; al_wr = 1'b0; al_en = 1'b0; al_clr = 1'b0;
        h12 = 1'b0; ld_sec = 6'd0; ld_min = 6'd0; ld_hr = 5'd0; al_min = 6'd0; al_hr = 5'd0;

        // Reset state
        step();
        step();
        check("rst_sec", sec_c, 0);
        check("rst_min", min_c, 0);
        check("rst_hr", hr_c, 0);
        check("rst_tick", tick_c, 0);
        check("rst_alarm", al_c, 0);
        check("rst_disp24", dhr_c, 0);
        check("rst_pm24", pm_c, 0);
        h12 = 1'b1; #1;
        check("rst_disp12", dhr_c, 12);
        check("rst_pm12", pm_c, 0);
        h12 = 1'b0;

        // CLK_DIV=4: ticks on enabled cycles 4, 8, 12
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("div4_tick_c%0d", i), tick_c, ((i % 4) == 0) ? 1 : 0);
        end
        check("div4_sec", sec_c, 3);

        // CLK_DIV=1: 23:59:58 -> 23:59:59 -> 00:00:00
        do_load(5'd23, 6'd59, 6'd58);
        check("ld_tick_suppressed", tick_a, 0);
        check("ld_sec58", sec_a, 58);
        step();
        check("wrap_s59", sec_a, 59);
        check("wrap_tick", tick_a, 1);
        step();
        check("wrap_hr", hr_a, 0);
        check("wrap_min", min_a, 0);
        check("wrap_sec", sec_a, 0);

        // Alarm 07:30 set by tick
        en = 1'b0; al_en = 1'b1; al_wr = 1'b1; al_min = 6'd30; al_hr = 5'd7;
        do_load(5'd7, 6'd29, 6'd59);
        al_wr = 1'b0;
        check("al_pre", al_a, 0);
        en = 1'b1;
        step();
        en = 1'b0;
        check("al_hr7", hr_a, 7);
        check("al_min30", min_a, 30);
        check("al_sec0", sec_a, 0);
        check("al_set", al_a, 1);
        // Sticky with al_en low
        al_en = 1'b0;
        step();
        check("al_sticky", al_a, 1);
        al_clr = 1'b1;
        step();
        al_clr = 1'b0;
        check("al_clr", al_a, 0);
        al_en = 1'b1;
        do_load(5'd7, 6'd30, 6'd0);
        check("al_no_ld_set", al_a, 0);
        step();
        check("al_no_ld_set2", al_a, 0);
        // Set wins over simultaneous clear
        do_load(5'd7, 6'd29, 6'd59);
        en = 1'b1; al_clr = 1'b1;
        step();
        en = 1'b0; al_clr = 1'b0;
        check("al_set_wins", al_a, 1);
        // Alarm disabled: no set on match
        al_clr = 1'b1; step(); al_clr = 1'b0;
        al_en = 1'b0;
        do_load(5'd7, 6'd29, 6'd59);
        en = 1'b1; step(); en = 1'b0;
        check("al_disabled", al_a, 0);
        // Out-of-range alarm write becomes 00:00
        al_en = 1'b1; al_wr = 1'b1; al_min = 6'd61; al_hr = 5'd30;
        do_load(5'd23, 6'd59, 6'd59);
        al_wr = 1'b0;
        en = 1'b1; step(); en = 1'b0;
        check("al_oor_midnight", al_a, 1);
        al_clr = 1'b1; step(); al_clr = 1'b0;
        al_en = 1'b0;

        // Out-of-range load fields
        do_load(5'd25, 6'd12, 6'd60);
        check("oor_sec", sec_a, 0);
        check("oor_min", min_a, 12);
        check("oor_hr", hr_a, 0);

        // 12-hour display
        h12 = 1'b1; #1;
        check("h12_0_disp", dhr_a, 12);
        check("h12_0_pm", pm_a, 0);
        do_load(5'd12, 6'd0, 6'd0);
        check("h12_12_disp", dhr_a, 12);
        check("h12_12_pm", pm_a, 1);
        do_load(5'd13, 6'd0, 6'd0);
        check("h12_13_disp", dhr_a, 1);
        check("h12_13_pm", pm_a, 1);
        h12 = 1'b0; #1;
        check("h24_13_disp", dhr_a, 13);
        check("h24_13_pm", pm_a, 1);

        // CLK_DIV=3: reset mid-second with ld and en active
        do_load(5'd0, 6'd0, 6'd0);
        en = 1'b1;
        step();
        rst = 1'b1; ld = 1'b1; ld_hr = 5'd5; ld_min = 6'd6; ld_sec = 6'd7;
        step();
        check("rst3_sec", sec_b, 0);
        check("rst3_min", min_b, 0);
        check("rst3_hr", hr_b, 0);
        check("rst3_tick", tick_b, 0);
        check("rst3_alarm", al_b, 0);
        check("rst3_disp", dhr_b, 0);
        check("rst3_pm", pm_b, 0);
        rst = 1'b0; ld = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("div3_tick_c%0d", i), tick_b, (i == 3) ? 1 : 0);
        end
        check("div3_sec", sec_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_rtc_alarm.md
PARAM_RTC_ALARM -- requirements
Module: param_rtc_alarm

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 1, meaning clk cycles per one-second tick (legal range 1..2^24).
REQ-002 SHALL size the prescaler counter as clog2(CLK_DIV) bits, minimum 1 bit.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, run enable for the prescaler and time counters.
REQ-006 SHALL have ports ld (1), ld_sec (6), ld_min (6) and ld_hr (5), all inputs, to load the time.
REQ-007 SHALL have ports al_wr (1), al_min (6) and al_hr (5), all inputs, to write the alarm time.
REQ-008 SHALL have ports al_en (1) and al_clr (1), inputs, for alarm enable and alarm flag clear.
REQ-009 SHALL have port h12, input, 1 bit, selecting 12-hour display format.
REQ-010 SHALL have ports sec (6), min (6) and hr (5), outputs, holding the registered 24-hour time.
REQ-011 SHALL have port tick, output, 1 bit, a one-cycle pulse on each second increment.
REQ-012 SHALL have port alarm, output, 1 bit, a sticky alarm flag.
REQ-013 SHALL have ports disp_hr (5) and pm (1), outputs, giving the formatted hour.

Function
REQ-014 SHALL hold the prescaler when en=0; when en=1 it counts 0..CLK_DIV-1 and wraps to 0.
REQ-015 SHALL register tick=1 for exactly one cycle when en=1 and the prescaler equals CLK_DIV-1; with CLK_DIV=1, tick=1 on every enabled cycle.
REQ-016 SHALL update sec/min/hr in the same edge that asserts tick; sec, min and hr never hold 60, 60 or 24.
REQ-017 SHALL wrap sec 59->0 and then increment min.
REQ-018 SHALL wrap min 59->0 together with sec 59->0, and then increment hr.
REQ-019 SHALL wrap hr 23->0 when sec, min and hr are all at 59, 59 and 23 (23:59:59 -> 00:00:00).
REQ-020 SHALL, when ld=1, load ld_sec/ld_min/ld_hr, clear the prescaler and suppress tick that cycle; ld has priority over en and tick.
REQ-021 SHALL load 0 for any out-of-range ld field (sec>59, min>59, hr>23) while loading the other fields normally.
REQ-022 SHALL, when al_wr=1, capture al_min/al_hr into the internal alarm registers, with out-of-range values replaced by 0.
REQ-023 SHALL set alarm on the edge where a tick produces the time al_hr:al_min:00 while al_en=1.
REQ-024 SHALL never set alarm from a ld or al_wr event, even if the resulting time matches.
REQ-025 SHALL clear alarm on al_clr=1; if a set and al_clr occur in the same cycle, set wins.
REQ-026 SHALL leave alarm held when al_en goes 0; only al_clr or rst clears it.
REQ-027 SHALL compute disp_hr/pm combinationally from hr.
REQ-028 SHALL set pm=1 when hr>=12, in both display formats.
REQ-029 SHALL set disp_hr=hr when h12=0.
REQ-030 SHALL, when h12=1, map hr=0 to 12, hr 1..12 to hr, and hr 13..23 to hr-12.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, clear sec, min, hr, the prescaler, tick, alarm and the alarm registers to 0; rst overrides ld, al_wr and en.
REQ-032 SHALL have rst asserted mid-second discard the partial prescaler count, so the first tick after reset comes CLK_DIV enabled cycles after rst is released.
REQ-033 SHALL have the outputs after reset be disp_hr=0 and pm=0 when h12=0, and disp_hr=12 and pm=0 when h12=1.

Verification
REQ-034 SHALL cover: CLK_DIV=4, rst then en=1 for 12 cycles -> tick on cycles 4, 8 and 12, sec=3.
REQ-035 SHALL cover: ld 23:59:58, en=1, CLK_DIV=1 -> after 2 cycles 00:00:00, wrap completes in a single tick.
REQ-036 SHALL cover: al_wr 07:30, al_en=1, ld 07:29:59, one tick -> 07:30:00 and alarm=1; al_clr -> 0; ld 07:30:00 -> alarm stays 0.
REQ-037 SHALL cover: ld with ld_sec=60, ld_min=12, ld_hr=25 -> sec=0, min=12, hr=0.
REQ-038 SHALL cover: h12=1 across hr 0, 12 and 13 -> disp_hr/pm of 12/0, 12/1 and 1/1.
REQ-039 SHALL cover: rst asserted with ld=1 and en=1, CLK_DIV=3, mid-second -> all outputs 0; first tick 3 cycles after rst is released.
